uart_rx_core: RTL
=================

# uart_rx_core

Single-clock UART receiver with a built-in receive FIFO: the receive-side counterpart of the transmit path. It synchronizes the serial `rx` line, detects start bits, and samples data bits at mid-bit using a parameterized oversampling tick. It also checks the stop bit and buffers completed words for the host, which reads them with a `rd_uart` handshake. It sits between the external serial pin and the host logic, clocked by `BCLK`.

## Interface
Parameters:
- `OVERSAMPLE`, 16: ticks per bit; even, ≥4.
- `DATA_WIDTH`, 8: data bits per frame, sent LSB first.
- `DIVISOR`, 27: `BCLK` cycles per oversample tick; ≥1.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of two, ≥2.

Ports:
- `BCLK`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial input; asynchronous, idle high.
- `rd_uart`  in  1  pop request; pops the head word when `rx_empty`=0.
- `R_data`  out  `DATA_WIDTH`  head-of-FIFO word; 0 while `rx_empty`=1.
- `rx_empty`  out  1  FIFO empty.
- `rx_full`  out  1  FIFO full.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: word dropped because the FIFO was full.

## Operation
- **Reset values.** While `reset`=0: synchronizer flops = 1, FSM = IDLE, counters = 0, FIFO empty, `R_data`=0, `rx_empty`=1, `rx_full`=0, `frame_err`=0, `overrun`=0.
- **Synchronizer.** `rx` passes through a 2-flop synchronizer. All logic uses the synchronized value `rxs`. `rxs_d` is `rxs` delayed by one cycle.
- **Tick generator.** Counter runs 0..`DIVISOR`-1. `tick`=1 in the cycle the count equals `DIVISOR`-1, then the count wraps to 0. In IDLE the counter is held at 0. A start edge restarts it.
- **FSM states:** IDLE, START, DATA, STOP. Tick counter `s` is `$clog2(OVERSAMPLE)` bits. Bit counter `n` is `$clog2(DATA_WIDTH)` bits; it needs at least 1 bit.
  - **IDLE.** On a falling edge (`rxs_d`=1, `rxs`=0) in any cycle: go to START with `s`=0.
  - **START.** On each tick, `s`++. At the tick where `s`=`OVERSAMPLE`/2-1 (mid start bit):
    - `rxs`=0 → go to DATA with `s`=0, `n`=0.
    - `rxs`=1 → glitch; return to IDLE. No flag is raised.
  - **DATA.** At the tick where `s`=`OVERSAMPLE`-1, shift `rxs` into the MSB of the shift register (right shift) and set `s`=0. After bit `DATA_WIDTH`-1, go to STOP.
  - **STOP.** At the tick where `s`=`OVERSAMPLE`-1, go to IDLE and sample `rxs`:
    - `rxs`=1, FIFO not full (after any same-cycle pop) → push the shift register.
    - `rxs`=1, FIFO full with no same-cycle pop → drop the word; `overrun`=1 for one cycle.
    - `rxs`=0 → discard the word; `frame_err`=1 for one cycle.
- **Break.** Because IDLE requires a falling edge, a line held low produces exactly one `frame_err` and no further frames until `rxs` returns high.
- **FIFO.** Show-ahead. `R_data` = mem[rptr].
  - `rd_uart`=1 while `rx_empty`=0 pops.
  - `rd_uart`=1 while `rx_empty`=1 is ignored; no pointer change.
  - Push and pop in the same cycle: both occur and the count is unchanged. This also applies when the FIFO is full, so no overrun occurs.
  - Pointers are `$clog2(FIFO_DEPTH)`+1 bits, wrapping naturally. Full and empty are decoded from the MSB and the remaining bits.
- **Reset mid-frame.** Asserting `reset` aborts the frame and empties the FIFO. Partial data is lost.

## Timing
- `rx` to `rxs`: 2 `BCLK` cycles.
- Start falling edge on `rxs` to the mid-start sample: `OVERSAMPLE`/2 ticks.
- Sample spacing: one sample every `OVERSAMPLE` ticks thereafter.
- Full frame: `(1.5+DATA_WIDTH)·OVERSAMPLE·DIVISOR` cycles from the start edge to the stop sample.
- Push: `rx_empty` falls (and `R_data` is valid) in the cycle after the stop-sample tick.
- Pop: the next head word, or `rx_empty`=1, appears in the cycle after the `rd_uart` edge.
- `frame_err` and `overrun` are registered. Each is asserted in the cycle after the stop-sample tick, for exactly one cycle.

## Structure
- Package `uart_pkg`:
  - typedef `rx_state_t` {IDLE, START, DATA, STOP}.
  - Default constants `OVERSAMPLE`, `DATA_WIDTH`.
- Sub-module `rx_sync_fifo`: single-clock, show-ahead FIFO parameterized by `DATA_WIDTH` and `FIFO_DEPTH`, with the same reset. It is instantiated once.
- The FSM, tick generator and synchronizer live in `uart_rx_core`.

## Test plan
Unless noted, use `DIVISOR`=4 and `OVERSAMPLE`=16, giving a 64-cycle bit.
- **Single frame.** Send 8'hA5 with a valid stop bit. Expect `rx_empty` to fall the cycle after the stop sample, and `R_data`=8'hA5. One `rd_uart` pulse → `rx_empty`=1, `R_data`=0.
- **Bad stop bit.** Send 8'h3C with the stop bit low. Expect one `frame_err` pulse and `rx_empty` still 1. Hold the line low for 30 bit times → no further `frame_err`.
- **Glitch rejection.** Drive a 20-cycle low pulse on idle `rx`. Expect the FSM back in IDLE with no push and no flags.
- **Overrun.** Receive 5 frames (8'h01..8'h05) without reading. Expect `rx_full`=1 after 4 frames and an `overrun` pulse on the 5th. Four reads then return 01, 02, 03, 04.
- **Simultaneous push and pop.** With the FIFO full, assert `rd_uart` in the exact push cycle. Expect no `overrun`, `rx_full` to remain 1, and the new word to be queued last.
- **Reset mid-frame.** Pulse `reset` low during DATA bit 4 with one word already queued. Expect all outputs at reset values. A following frame 8'h5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and default frame constants for the UART receive path.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_WIDTH = 8;

endpackage

// File: rtl/uart_rx_core_if.sv
// Host-side read port of the UART receiver: pop handshake, head word and status flags.
interface uart_rx_core_if #(
  parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH
) ();

  logic                  rd_uart;
  logic [DATA_WIDTH-1:0] R_data;
  logic                  rx_empty;
  logic                  rx_full;
  logic                  frame_err;
  logic                  overrun;

  modport master (
    output rd_uart,
    input  R_data, rx_empty, rx_full, frame_err, overrun
  );

  modport slave (
    input  rd_uart,
    output R_data, rx_empty, rx_full, frame_err, overrun
  );

endinterface

// File: rtl/rx_sync_fifo.sv
// Single-clock show-ahead FIFO; the head word is presented combinationally and reads 0 when empty.
module rx_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full
);
  import uart_pkg::*;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic                  rd_ok;
  logic                  wr_ok;

  // Extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  assign rd_data = empty ? '0 : mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q + PW'(wr_ok);
    rptr_d = rptr_q + PW'(rd_ok);
    mem_d  = mem_q;
    if (wr_ok) begin
      mem_d[wptr_q[AW-1:0]] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: rx synchronizer, oversample tick generator, frame FSM and receive FIFO.
module uart_rx_core #(
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
  parameter int DATA_WIDTH = uart_pkg::DATA_WIDTH,
  parameter int DIVISOR    = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          BCLK,
  input  logic          reset,
  input  logic          rx,
  uart_rx_core_if.slave host
);
  import uart_pkg::*;

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int DW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;

  localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_LAST   = NW'(DATA_WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIVISOR - 1);

  logic                  meta_q, meta_d;
  logic                  rxs_q, rxs_d;
  logic                  rxs_prev_q, rxs_prev_d;
  logic [DW-1:0]         div_q, div_d;
  logic                  tick;
  rx_state_t             state_q, state_d;
  logic [SW-1:0]         s_q, s_d;
  logic [NW-1:0]         n_q, n_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  fall;
  logic                  stop_done;
  logic                  push;
  logic                  pop;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [DATA_WIDTH-1:0] fifo_data;

  always_comb begin
    meta_d     = rx;
    rxs_d      = meta_q;
    rxs_prev_d = rxs_q;
  end

  assign fall = rxs_prev_q & ~rxs_q;
  assign tick = (div_q == DIV_LAST);

  // Held at zero while idle so the first tick lands exactly DIVISOR cycles after the start edge.
  always_comb begin
    div_d = '0;
    if (state_q != IDLE) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end
  end

  always_ff @(posedge BCLK or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sr_d    = sr_q;
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == S_MID) begin
            s_d     = '0;
            n_d     = '0;
            state_d = rxs_q ? IDLE : DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d  = '0;
            sr_d = {rxs_q, sr_q[DATA_WIDTH-1:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            state_d = IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop in the stop-sample cycle frees a slot, so a full FIFO still accepts the word.
  always_comb begin
    stop_done   = (state_q == STOP) && tick && (s_q == S_LAST);
    pop         = host.rd_uart & ~fifo_empty;
    push        = stop_done & rxs_q & (~fifo_full | pop);
    overrun_d   = stop_done & rxs_q & fifo_full & ~pop;
    frame_err_d = stop_done & ~rxs_q;
  end

  always_ff @(posedge BCLK or negedge reset) begin
    if (!reset) begin
      meta_q      <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_prev_q  <= 1'b1;
      div_q       <= '0;
      s_q         <= '0;
      n_q         <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      meta_q      <= meta_d;
      rxs_q       <= rxs_d;
      rxs_prev_q  <= rxs_prev_d;
      div_q       <= div_d;
      s_q         <= s_d;
      n_q         <= n_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge BCLK) begin
    sr_q <= sr_d;
  end

  rx_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (BCLK),
    .rst_n   (reset),
    .wr_en   (push),
    .wr_data (sr_q),
    .rd_en   (host.rd_uart),
    .rd_data (fifo_data),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign host.R_data    = fifo_data;
  assign host.rx_empty  = fifo_empty;
  assign host.rx_full   = fifo_full;
  assign host.frame_err = frame_err_q;
  assign host.overrun   = overrun_q;

endmodule
